// File: rtl/jt93cxx_if.sv
// rtl/jt93cxx_if.sv - Microwire pins and host dump port bundle for jt93cxx
interface jt93cxx_if #(
  parameter int DW = 16,
  parameter int AW = 6
);
  logic          sclk;
  logic          sdi;
  logic          scs;
  logic          sdo;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_din;
  logic          dump_we;
  logic [DW-1:0] dump_dout;
  logic          dirty;
  logic          dirty_clr;

  modport master (
    output sclk, sdi, scs, dump_addr, dump_din, dump_we, dirty_clr,
    input  sdo, dump_dout, dirty
  );

  modport slave (
    input  sclk, sdi, scs, dump_addr, dump_din, dump_we, dirty_clr,
    output sdo, dump_dout, dirty
  );
endinterface

// File: rtl/jt93cxx.sv
// rtl/jt93cxx.sv - 93C46/56/66/86 Microwire serial EEPROM emulator with host dump port
module jt93cxx #(
  parameter int DW       = 16,
  parameter int AW       = 6,
  parameter int BUSY_CYC = 64
) (
  input  logic     clk,
  input  logic     rst,
  jt93cxx_if.slave eep
);
  localparam int DEPTH = 1 << AW;
  localparam int BW    = $clog2(BUSY_CYC + 1);
  localparam int CW    = $clog2(AW + DW + 2);

  typedef enum logic [2:0] {IDLE, CMD, READ, WRDATA, BUSY, ALLOP} state_t;

  logic [DW-1:0] mem_q [DEPTH];

  state_t        state_q, state_d;
  logic          sclk_q;
  logic          sdo_q, sdo_d;
  logic          wen_q, wen_d;
  logic          all_q, all_d;
  logic          dirty_q, dirty_d;
  logic [CW-1:0] bit_q, bit_d;
  logic [AW:0]   cmd_q, cmd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [DW-1:0] fill_q, fill_d;
  logic [BW-1:0] busy_q, busy_d;
  logic [DW-1:0] dout_q;

  logic          sclk_rise;
  logic          step;
  logic [AW+1:0] cmd_word;
  logic [1:0]    opcode;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] wr_word;
  logic [AW-1:0] addr_inc;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  // The final command bit is combined with the AW+1 bits already shifted in.
  assign sclk_rise = eep.sclk & ~sclk_q;
  assign step      = sclk_rise & eep.scs;
  assign cmd_word  = {cmd_q, eep.sdi};
  assign opcode    = cmd_word[AW+1:AW];
  assign cmd_addr  = cmd_word[AW-1:0];
  assign wr_word   = {shift_q[DW-2:0], eep.sdi};
  assign addr_inc  = addr_q + AW'(1);

  assign eep.sdo       = sdo_q;
  assign eep.dirty     = dirty_q;
  assign eep.dump_dout = dout_q;

  // Track the previous serial clock level for rising-edge detection.
  always_ff @(posedge clk) begin
    sclk_q <= eep.sclk;
  end

  // Serial protocol next-state and memory write request.
  always_comb begin
    state_d   = state_q;
    sdo_d     = sdo_q;
    wen_d     = wen_q;
    all_d     = all_q;
    bit_d     = bit_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    shift_d   = shift_q;
    fill_d    = fill_q;
    busy_d    = busy_q;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = fill_q;
    case (state_q)
      IDLE: begin
        sdo_d = 1'b1;
        if (step && eep.sdi) begin
          state_d = CMD;
          bit_d   = '0;
          cmd_d   = '0;
        end
      end
      CMD: begin
        if (!eep.scs) begin
          state_d = IDLE;
          sdo_d   = 1'b1;
        end else if (sclk_rise) begin
          cmd_d = {cmd_q[AW-1:0], eep.sdi};
          bit_d = bit_q + CW'(1);
          if (bit_q == CW'(AW + 1)) begin
            addr_d  = cmd_addr;
            bit_d   = '0;
            all_d   = 1'b0;
            state_d = IDLE;
            case (opcode)
              2'b10: begin
                state_d = READ;
                sdo_d   = 1'b0;
                shift_d = mem_q[cmd_addr];
              end
              2'b01: state_d = WRDATA;
              2'b11: begin
                if (wen_q) begin
                  mem_we    = 1'b1;
                  mem_waddr = cmd_addr;
                  mem_wdata = '1;
                  state_d   = BUSY;
                  busy_d    = BW'(BUSY_CYC);
                  sdo_d     = 1'b0;
                end
              end
              default: begin
                case (cmd_addr[AW-1:AW-2])
                  2'b11: wen_d = 1'b1;
                  2'b00: wen_d = 1'b0;
                  2'b10: begin
                    if (wen_q) begin
                      state_d = ALLOP;
                      fill_d  = '1;
                      addr_d  = '0;
                      sdo_d   = 1'b0;
                    end
                  end
                  default: begin
                    state_d = WRDATA;
                    all_d   = 1'b1;
                  end
                endcase
              end
            endcase
          end
        end
      end
      READ: begin
        if (!eep.scs) begin
          state_d = IDLE;
          sdo_d   = 1'b1;
        end else if (sclk_rise) begin
          sdo_d   = shift_q[DW-1];
          shift_d = {shift_q[DW-2:0], 1'b0};
          bit_d   = bit_q + CW'(1);
          // Next word follows the last bit directly, no dummy bit in between.
          if (bit_q == CW'(DW - 1)) begin
            bit_d   = '0;
            addr_d  = addr_inc;
            shift_d = mem_q[addr_inc];
          end
        end
      end
      WRDATA: begin
        if (!eep.scs) begin
          state_d = IDLE;
          sdo_d   = 1'b1;
        end else if (sclk_rise) begin
          shift_d = wr_word;
          bit_d   = bit_q + CW'(1);
          if (bit_q == CW'(DW - 1)) begin
            bit_d   = '0;
            state_d = IDLE;
            if (wen_q) begin
              sdo_d = 1'b0;
              if (all_q) begin
                state_d = ALLOP;
                fill_d  = wr_word;
                addr_d  = '0;
              end else begin
                mem_we    = 1'b1;
                mem_waddr = addr_q;
                mem_wdata = wr_word;
                state_d   = BUSY;
                busy_d    = BW'(BUSY_CYC);
              end
            end
          end
        end
      end
      BUSY: begin
        sdo_d  = 1'b0;
        busy_d = busy_q - BW'(1);
        if (busy_q <= BW'(1)) begin
          state_d = IDLE;
          sdo_d   = 1'b1;
          busy_d  = '0;
        end
      end
      ALLOP: begin
        sdo_d     = 1'b0;
        mem_we    = 1'b1;
        mem_waddr = addr_q;
        mem_wdata = fill_q;
        addr_d    = addr_inc;
        if (&addr_q) begin
          state_d = BUSY;
          busy_d  = BW'(BUSY_CYC);
        end
      end
      default: state_d = IDLE;
    endcase
    // A serial commit in the same cycle as dirty_clr keeps the flag set.
    dirty_d = mem_we ? 1'b1 : (eep.dirty_clr ? 1'b0 : dirty_q);
  end

  // Protocol state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sdo_q   <= 1'b1;
      wen_q   <= 1'b0;
      all_q   <= 1'b0;
      dirty_q <= 1'b0;
      bit_q   <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      shift_q <= '0;
      fill_q  <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      sdo_q   <= sdo_d;
      wen_q   <= wen_d;
      all_q   <= all_d;
      dirty_q <= dirty_d;
      bit_q   <= bit_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      fill_q  <= fill_d;
      busy_q  <= busy_d;
    end
  end

  // Storage: serial commits take priority over host writes; reset blocks serial writes only.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_waddr] <= mem_wdata;
    end else if (eep.dump_we) begin
      mem_q[eep.dump_addr] <= eep.dump_din;
    end
    dout_q <= mem_q[eep.dump_addr];
  end
endmodule
